cordic_phase_gen: RTL and testbench
===================================

Name: cordic_phase_gen

Overview:
- Phase-accumulator front end for the pipelined CORDIC sin/cos stage.
- Produces a stream of signed fixed-point angles in [-PI, PI), scaled at 2^14 per radian, with valid/ready handshake. Each sample advances by a programmable frequency word.
- Bursts are either a programmed number of samples or continuous until stopped.
- Output `angle` connects directly to the CORDIC `angle` input.

Parameters:
- BITS, 16, angle magnitude width; angle ports are BITS+1 bits signed.
- PI, 51472, pi in angle units (pi * 2^14, rounded).
- CNT_W, 16, width of burst length and sample counter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  pulse; begins a burst when idle.
- stop  input  1  pulse; ends the current burst early.
- phase_init  input  BITS+1 signed  first angle of burst, sampled on accepted start.
- freq_word  input  BITS+1 signed  per-sample phase increment, sampled on accepted start.
- burst_len  input  CNT_W  samples per burst; 0 = continuous.
- out_ready  input  1  downstream accepts angle this cycle.
- out_valid  output  1  angle is valid.
- angle  output  BITS+1 signed  current phase, always within [-PI, PI-1].
- busy  output  1  high in RUN state.
- done  output  1  one-cycle pulse at burst end, normal or stopped.
- wrap  output  1  one-cycle pulse when the accepted update wrapped.

Behaviour:
- Reset (rst=1 at edge) sets state IDLE. Outputs: out_valid=0, angle=0, busy=0, done=0, wrap=0. Accumulator, counter and latched words are cleared. Reset overrides everything, including mid-burst; no done pulse is issued.
- FSM states: IDLE and RUN.
- IDLE, start=1:
  - latch freq_word (saturated to [-PI, PI]) and burst_len;
  - set angle = wrap(phase_init); count = 0;
  - next cycle: state RUN, busy=1, out_valid=1.
  - Latency from start to first valid is 1 cycle.
- RUN: out_valid stays 1. Handshake fires when out_valid & out_ready.
  - On handshake, angle <= wrap(angle + freq_q) and count++.
  - Without handshake, angle is held stable.
- Wrap arithmetic:
  - sum is computed at BITS+3 bits signed;
  - if sum >= PI then sum - 2*PI;
  - else if sum < -PI then sum + 2*PI;
  - otherwise sum unchanged.
  - A single correction always suffices because |freq_q| <= PI and angle is in range.
  - wrap pulses the cycle after a handshake whose update corrected.
  - phase_init is wrapped by the same function; it is assumed to lie within ±2*PI-1.
- Burst end:
  - when burst_len != 0 and a handshake occurs with count == burst_len-1: next cycle state IDLE, out_valid=0, busy=0, done=1 for one cycle.
  - angle retains the post-update value.
- stop in RUN:
  - any handshake in the same cycle still counts and updates angle;
  - next cycle state IDLE, out_valid=0, done=1.
  - stop together with the final handshake gives a single done pulse.
- start while RUN is ignored. stop while IDLE is ignored.
- start and stop together in IDLE: start wins.
- Continuous mode: count wraps modulo 2^CNT_W silently; the burst never self-terminates.
- done and start may coincide in IDLE; a new burst begins normally.

Decomposition:
- Shared package cordic_pkg:
  - ANGLE_W = BITS+1;
  - PI and TWO_PI constants, kept consistent with the CORDIC atan table scale;
  - state enum {IDLE, RUN}.
- One combinational sub-module, phase_wrap (sum in, wrapped angle and wrapped flag out). It is instantiated twice: once for phase_init and once for the accumulator update.

Test Plan:
- init=0, freq=12868, burst=9, ready=1 → angles 0, 12868, 25736, 38604, -51472, -38604, -25736, -12868, 0; wrap after 4th accept; done one cycle after 9th accept; out_valid=0 afterwards.
- init=-51472, freq=-1, burst=3 → -51472, 51471, 51470; wrap on first update.
- Same as test 1 with out_ready low for 3 cycles after 2nd sample → angle holds 25736 and count frozen; sequence resumes identically.
- freq=60000 (saturates to 51472), init=0, burst=4 → 0, -51472, 0, -51472.
- burst=0, stop after 20 handshakes (stop with handshake) → 20 samples; single done; busy falls next cycle. start asserted mid-run → no effect.
- rst asserted mid-burst → next cycle out_valid=0, angle=0, busy=0, done=0. New start works normally.

Source files
------------

// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cordic_pkg
// Description : Shared constants and types for the CORDIC phase front end.
//               Angles are signed fixed point at 2^14 units per radian, which
//               matches the scale of the CORDIC arctangent table.
// Contents    : ANGLE_W, PI, TWO_PI, CNT_W defaults; state_t {IDLE, RUN}
// Revision    : 1.0 - initial release
// ============================================================================
package cordic_pkg;

    localparam int BITS    = 16;
    localparam int ANGLE_W = BITS + 1;
    localparam int PI      = 51472;     // round(pi * 2^14)
    localparam int TWO_PI  = 2 * PI;
    localparam int CNT_W   = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage : cordic_pkg
`default_nettype wire

// File: rtl/phase_wrap.sv
`default_nettype none
// ============================================================================
// Module      : phase_wrap
// Description : Folds a widened angle sum back into [-PI, PI-1] with a single
//               +/- 2*PI correction. Purely combinational.
// Ports       : sum_i     - BITS+3 bit signed sum, within [-2*PI, 2*PI-1]
//               angle_o   - BITS+1 bit signed wrapped angle
//               wrapped_o - high when a correction was applied
// Revision    : 1.0 - initial release
// ============================================================================
module phase_wrap
    import cordic_pkg::*;
#(
    parameter int BITS = 16,
    parameter int PI   = 51472
) (
    input  logic signed [BITS+2:0] sum_i,
    output logic signed [BITS:0]   angle_o,
    output logic                   wrapped_o
);

    localparam int                 c_TWO_PI_INT = 2 * PI;
    localparam logic signed [BITS+2:0] c_PI_W     = PI[BITS+2:0];
    localparam logic signed [BITS+2:0] c_NEG_PI_W = -c_PI_W;
    // 2*PI does not fit in BITS+1 signed bits, but only the low bits of the
    // corrected result are kept, so modular arithmetic on the low bits gives
    // the same answer as the full-width correction.
    localparam logic [BITS:0]      c_TWO_PI_LO  = c_TWO_PI_INT[BITS:0];

    logic [BITS:0] w_sum_lo;

    assign w_sum_lo = sum_i[BITS:0];

    always_comb begin
        angle_o   = w_sum_lo;
        wrapped_o = 1'b0;
        if (sum_i >= c_PI_W) begin
            angle_o   = w_sum_lo - c_TWO_PI_LO;
            wrapped_o = 1'b1;
        end else if (sum_i < c_NEG_PI_W) begin
            angle_o   = w_sum_lo + c_TWO_PI_LO;
            wrapped_o = 1'b1;
        end
    end

endmodule : phase_wrap
`default_nettype wire

// File: rtl/cordic_phase_gen.sv
`default_nettype none
// ============================================================================
// Module      : cordic_phase_gen
// Description : Phase accumulator feeding the pipelined CORDIC. Emits a
//               valid/ready stream of angles in [-PI, PI-1], advancing by a
//               saturated frequency word on every accepted sample. Bursts are
//               either burst_len samples long or continuous (burst_len = 0)
//               until stop.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               start, stop         - burst begin / early end pulses
//               phase_init          - first angle (wrapped), taken on start
//               freq_word           - per-sample increment, taken on start
//               burst_len           - samples per burst, 0 = continuous
//               out_ready/out_valid - output handshake
//               angle               - current phase
//               busy, done, wrap    - status (RUN, end pulse, wrap pulse)
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_phase_gen
    import cordic_pkg::*;
#(
    parameter int BITS  = 16,
    parameter int PI    = 51472,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic signed [BITS:0]  phase_init,
    input  logic signed [BITS:0]  freq_word,
    input  logic [CNT_W-1:0]      burst_len,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic signed [BITS:0]  angle,
    output logic                  busy,
    output logic                  done,
    output logic                  wrap
);

    localparam logic signed [BITS:0] c_PI_A     = PI[BITS:0];
    localparam logic signed [BITS:0] c_NEG_PI_A = -c_PI_A;
    localparam logic [CNT_W-1:0]     c_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t                 state_q;
    logic                   out_valid_q;
    logic signed [BITS:0]   angle_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   wrap_q;
    logic signed [BITS:0]   freq_q;
    logic [CNT_W-1:0]       len_q;
    logic [CNT_W-1:0]       cnt_q;

    logic signed [BITS:0]   freq_sat_d;
    logic signed [BITS+2:0] w_init_sum;
    logic signed [BITS+2:0] acc_sum_d;
    logic signed [BITS:0]   init_angle_d;
    logic signed [BITS:0]   acc_angle_d;
    logic                   acc_wrapped_d;
    logic                   w_init_wrapped_unused;
    logic                   w_hs;
    logic                   w_last;

    // Clamping the increment to [-PI, PI] guarantees one wrap correction
    // per update is always enough.
    always_comb begin
        freq_sat_d = freq_word;
        if (freq_word > c_PI_A) begin
            freq_sat_d = c_PI_A;
        end else if (freq_word < c_NEG_PI_A) begin
            freq_sat_d = c_NEG_PI_A;
        end
    end

    assign w_init_sum = {{2{phase_init[BITS]}}, phase_init};
    assign acc_sum_d  = {{2{angle_q[BITS]}}, angle_q} + {{2{freq_q[BITS]}}, freq_q};

    phase_wrap #(
        .BITS (BITS),
        .PI   (PI)
    ) u_wrap_init (
        .sum_i     (w_init_sum),
        .angle_o   (init_angle_d),
        .wrapped_o (w_init_wrapped_unused)
    );

    phase_wrap #(
        .BITS (BITS),
        .PI   (PI)
    ) u_wrap_acc (
        .sum_i     (acc_sum_d),
        .angle_o   (acc_angle_d),
        .wrapped_o (acc_wrapped_d)
    );

    assign w_hs   = out_valid_q & out_ready;
    assign w_last = (len_q != '0) && (cnt_q == (len_q - c_ONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            angle_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wrap_q      <= 1'b0;
            freq_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
        end else begin
            done_q <= 1'b0;
            wrap_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // start has priority over a coincident stop here
                    if (start) begin
                        freq_q      <= freq_sat_d;
                        len_q       <= burst_len;
                        angle_q     <= init_angle_d;
                        cnt_q       <= '0;
                        state_q     <= RUN;
                        busy_q      <= 1'b1;
                        out_valid_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (w_hs) begin
                        angle_q <= acc_angle_d;
                        cnt_q   <= cnt_q + c_ONE;   // wraps silently in continuous mode
                        wrap_q  <= acc_wrapped_d;
                    end
                    // stop and a final handshake together still yield one done
                    if (stop || (w_hs && w_last)) begin
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign angle     = angle_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign wrap      = wrap_q;

endmodule : cordic_phase_gen
`default_nettype wire

// File: tb/tb_cordic_phase_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_cordic_phase_gen
// Description : Directed self-checking bench for cordic_phase_gen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_phase_gen;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               stop;
    logic signed [16:0] phase_init;
    logic signed [16:0] freq_word;
    logic [15:0]        burst_len;
    logic               out_ready;
    logic               out_valid;
    logic signed [16:0] angle;
    logic               busy;
    logic               done;
    logic               wrap;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cordic_phase_gen #(
        .BITS  (16),
        .PI    (51472),
        .CNT_W (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .phase_init (phase_init),
        .freq_word  (freq_word),
        .burst_len  (burst_len),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .angle      (angle),
        .busy       (busy),
        .done       (done),
        .wrap       (wrap)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input string tag, input int exp_a, input bit exp_w);
        chk({tag, ".valid"}, out_valid, 1);
        chk({tag, ".busy"},  busy,      1);
        chk({tag, ".done"},  done,      0);
        chk({tag, ".angle"}, angle,     exp_a);
        chk({tag, ".wrap"},  wrap,      exp_w);
    endtask

    task automatic ended(input string tag, input int exp_a);
        chk({tag, ".done"},  done,      1);
        chk({tag, ".valid"}, out_valid, 0);
        chk({tag, ".busy"},  busy,      0);
        chk({tag, ".angle"}, angle,     exp_a);
    endtask

    int exp1 [9] = '{0, 12868, 25736, 38604, -51472, -38604, -25736, -12868, 0};

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        phase_init = '0; freq_word = '0; burst_len = '0; out_ready = 1'b0;
        tick();
        tick();
        chk("rst.valid", out_valid, 0);
        chk("rst.angle", angle, 0);
        chk("rst.busy",  busy, 0);
        chk("rst.done",  done, 0);
        chk("rst.wrap",  wrap, 0);
        rst = 1'b0;
        tick();

        // ---- Test 1: quarter-turn steps, burst of 9
        phase_init = 17'sd0; freq_word = 17'sd12868; burst_len = 16'd9;
        out_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            sample($sformatf("t1.s%0d", i), exp1[i], (i == 4));
            tick();
        end
        ended("t1.end", 12868);
        tick();
        chk("t1.done_clr", done, 0);
        chk("t1.idle_valid", out_valid, 0);

        // ---- Test 2: negative step from -PI; start+stop together, start wins
        phase_init = -17'sd51472; freq_word = -17'sd1; burst_len = 16'd3;
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        sample("t2.s0", -51472, 1'b0);
        tick();
        sample("t2.s1", 51471, 1'b1);
        tick();
        sample("t2.s2", 51470, 1'b0);
        tick();
        ended("t2.end", 51469);

        // ---- Test 4 launched while done is high: saturated frequency
        phase_init = 17'sd0; freq_word = 17'sd60000; burst_len = 16'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        sample("t4.s0", 0, 1'b0);
        tick();
        sample("t4.s1", -51472, 1'b1);
        tick();
        sample("t4.s2", 0, 1'b0);
        tick();
        sample("t4.s3", -51472, 1'b1);
        tick();
        ended("t4.end", 0);
        tick();

        // ---- Test 3: test 1 with a 3-cycle stall after the 2nd sample
        phase_init = 17'sd0; freq_word = 17'sd12868; burst_len = 16'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        sample("t3.s0", 0, 1'b0);
        tick();
        sample("t3.s1", 12868, 1'b0);
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample($sformatf("t3.hold%0d", i), 25736, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        for (int i = 2; i < 9; i++) begin
            sample($sformatf("t3.s%0d", i), exp1[i], (i == 4));
            tick();
        end
        ended("t3.end", 12868);
        tick();

        // ---- Test 5: continuous, stop with the 20th handshake, start ignored
        phase_init = 17'sd0; freq_word = 17'sd1000; burst_len = 16'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sample($sformatf("t5.s%0d", i), i * 1000, 1'b0);
            start      = (i >= 10 && i <= 12);
            phase_init = (i >= 10 && i <= 12) ? 17'sd7777 : 17'sd0;
            freq_word  = (i >= 10 && i <= 12) ? 17'sd5 : 17'sd1000;
            stop       = (i == 19);
            tick();
        end
        start = 1'b0; stop = 1'b0;
        ended("t5.end", 20000);
        tick();
        chk("t5.done_once", done, 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t5.idle_stop_done", done, 0);
        chk("t5.idle_stop_busy", busy, 0);

        // ---- Test 6: reset mid-burst, then a fresh burst
        phase_init = 17'sd100; freq_word = 17'sd200; burst_len = 16'd10;
        start = 1'b1;
        tick();
        start = 1'b0;
        sample("t6.s0", 100, 1'b0);
        tick();
        sample("t6.s1", 300, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6.rst_valid", out_valid, 0);
        chk("t6.rst_angle", angle, 0);
        chk("t6.rst_busy",  busy, 0);
        chk("t6.rst_done",  done, 0);
        tick();
        chk("t6.post_done", done, 0);
        phase_init = 17'sd5000; freq_word = 17'sd200; burst_len = 16'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        sample("t6.n0", 5000, 1'b0);
        tick();
        sample("t6.n1", 5200, 1'b0);
        tick();
        ended("t6.end", 5400);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_cordic_phase_gen
`default_nettype wire
